// File: rtl/controlador_busca_parametrizado.sv
// Search-job controller: queues (origem, destino) requests in a small FIFO and
// sequences each job through evaluation, buffer update, expansion and path
// build phases, with an iteration limit, abort and result acknowledge.
module controlador_busca_parametrizado #(
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ITER_WIDTH = 12,
    parameter int MAX_ITER   = 4000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid_in,
    input  logic [ADDR_WIDTH-1:0]         req_origem_in,
    input  logic [ADDR_WIDTH-1:0]         req_destino_in,
    output logic                          req_ready_out,
    input  logic                          tem_ativo_in,
    input  logic                          aa_pronto_in,
    input  logic                          lvv_pronto_in,
    input  logic                          caminho_pronto_in,
    input  logic                          lido_in,
    input  logic                          abortar_in,
    output logic                          aguardando_out,
    output logic                          iniciar_out,
    output logic                          atualizar_classificacao_out,
    output logic                          atualizar_buffer_out,
    output logic                          expandir_out,
    output logic                          construir_caminho_out,
    output logic                          caminho_pronto_out,
    output logic                          erro_out,
    output logic [ADDR_WIDTH-1:0]         origem_out,
    output logic [ADDR_WIDTH-1:0]         destino_out,
    output logic [ITER_WIDTH-1:0]         iteracoes_out,
    output logic [$clog2(FIFO_DEPTH):0]   fila_nivel_out
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]      DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [ITER_WIDTH-1:0] MAX_ITER_C = ITER_WIDTH'(MAX_ITER);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INIC      = 3'd1;
    localparam logic [2:0] S_TEM_ATIVO = 3'd2;
    localparam logic [2:0] S_ATU_BUF   = 3'd3;
    localparam logic [2:0] S_EXPANDIR  = 3'd4;
    localparam logic [2:0] S_CONSTRUIR = 3'd5;
    localparam logic [2:0] S_PRONTO    = 3'd6;
    localparam logic [2:0] S_ERRO      = 3'd7;

    logic [2:0]              state_q, state_d;
    logic [2*ADDR_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ITER_WIDTH-1:0]   iter_q, iter_d;
    logic [ADDR_WIDTH-1:0]   origem_q, origem_d;
    logic [ADDR_WIDTH-1:0]   destino_q, destino_d;
    logic                    expandir_q;

    logic full, empty, push, pop;

    // Full is taken from the registered count, so a same-cycle pop never frees room for a push
    assign full  = (cnt_q == DEPTH_C);
    assign empty = (cnt_q == '0);
    assign push  = req_valid_in && !full;
    assign pop   = (state_q == S_IDLE) && !empty;

    // Next-state logic; abort overrides every other transition outside IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (pop) state_d = S_INIC;
            S_INIC:      if (tem_ativo_in && aa_pronto_in) state_d = S_TEM_ATIVO;
            S_TEM_ATIVO: begin
                if (aa_pronto_in) begin
                    if (!tem_ativo_in)            state_d = S_CONSTRUIR;
                    else if (iter_q == MAX_ITER_C) state_d = S_ERRO;
                    else                           state_d = S_ATU_BUF;
                end
            end
            S_ATU_BUF:   if (aa_pronto_in) state_d = S_EXPANDIR;
            S_EXPANDIR:  if (lvv_pronto_in) state_d = S_TEM_ATIVO;
            S_CONSTRUIR: if (caminho_pronto_in) state_d = S_PRONTO;
            S_PRONTO,
            S_ERRO:      if (lido_in) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
        if (abortar_in && (state_q != S_IDLE)) state_d = S_IDLE;
    end

    // Job datapath: load endpoints and clear counter on pop, count expansions up to the limit
    always_comb begin
        origem_d  = origem_q;
        destino_d = destino_q;
        iter_d    = iter_q;
        if (pop) begin
            {origem_d, destino_d} = mem_q[rd_ptr_q];
            iter_d = '0;
        end else if ((state_q == S_ATU_BUF) && (state_d == S_EXPANDIR) && (iter_q != MAX_ITER_C)) begin
            iter_d = iter_q + 1'b1;
        end
    end

    // FIFO pointer and occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO storage; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {req_origem_in, req_destino_in};
    end

    // State and control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            iter_q     <= '0;
            origem_q   <= '0;
            destino_q  <= '0;
            expandir_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            iter_q     <= iter_d;
            origem_q   <= origem_d;
            destino_q  <= destino_d;
            expandir_q <= (state_q == S_EXPANDIR);
        end
    end

    assign req_ready_out               = !full;
    assign fila_nivel_out              = cnt_q;
    assign aguardando_out              = (state_q == S_IDLE);
    assign iniciar_out                 = (state_q == S_INIC);
    assign atualizar_classificacao_out = (state_q == S_TEM_ATIVO) || pop;
    assign atualizar_buffer_out        = (state_q == S_ATU_BUF) && aa_pronto_in;
    assign expandir_out                = expandir_q;
    assign construir_caminho_out       = (state_q == S_CONSTRUIR);
    assign caminho_pronto_out          = (state_q == S_PRONTO);
    assign erro_out                    = (state_q == S_ERRO);
    assign origem_out                  = origem_q;
    assign destino_out                 = destino_q;
    assign iteracoes_out               = iter_q;

endmodule

// File: tb/tb_controlador_busca_parametrizado.sv
// Directed bench for controlador_busca_parametrizado: request order is tracked
// in a scoreboard queue and checked when each job starts.
module tb_controlador_busca_parametrizado;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid_in;
    logic [7:0] req_origem_in, req_destino_in;
    logic       req_ready_out;
    logic       tem_ativo_in, aa_pronto_in, lvv_pronto_in, caminho_pronto_in, lido_in, abortar_in;
    logic       aguardando_out, iniciar_out, atualizar_classificacao_out, atualizar_buffer_out;
    logic       expandir_out, construir_caminho_out, caminho_pronto_out, erro_out;
    logic [7:0] origem_out, destino_out;
    logic [11:0] iteracoes_out;
    logic [2:0] fila_nivel_out;

    int checks = 0;
    int errors = 0;
    logic [15:0] sb[$];

    controlador_busca_parametrizado #(
        .ADDR_WIDTH(8),
        .FIFO_DEPTH(4),
        .ITER_WIDTH(12),
        .MAX_ITER(3)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_in(req_valid_in), .req_origem_in(req_origem_in), .req_destino_in(req_destino_in),
        .req_ready_out(req_ready_out),
        .tem_ativo_in(tem_ativo_in), .aa_pronto_in(aa_pronto_in), .lvv_pronto_in(lvv_pronto_in),
        .caminho_pronto_in(caminho_pronto_in), .lido_in(lido_in), .abortar_in(abortar_in),
        .aguardando_out(aguardando_out), .iniciar_out(iniciar_out),
        .atualizar_classificacao_out(atualizar_classificacao_out),
        .atualizar_buffer_out(atualizar_buffer_out), .expandir_out(expandir_out),
        .construir_caminho_out(construir_caminho_out), .caminho_pronto_out(caminho_pronto_out),
        .erro_out(erro_out), .origem_out(origem_out), .destino_out(destino_out),
        .iteracoes_out(iteracoes_out), .fila_nivel_out(fila_nivel_out)
    );

    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offer one request for one cycle; expected acceptance decides scoreboard entry
    task automatic push(input logic [7:0] o, input logic [7:0] d, input logic exp_acc);
        req_valid_in   = 1'b1;
        req_origem_in  = o;
        req_destino_in = d;
        #1;
        chk("req_ready", req_ready_out, exp_acc);
        if (exp_acc) sb.push_back({o, d});
        nxt();
        req_valid_in = 1'b0;
    endtask

    // Wait (bounded) for iniciar_out and compare endpoints against the oldest queued request
    task automatic expect_start();
        int n = 0;
        logic [15:0] e;
        while (!iniciar_out && n < 20) begin
            nxt();
            n++;
        end
        chk("start_seen", iniciar_out, 1);
        chk("sb_nonempty", sb.size() != 0, 1);
        if (iniciar_out && sb.size() != 0) begin
            e = sb.pop_front();
            chk("origem_start", origem_out, e[15:8]);
            chk("destino_start", destino_out, e[7:0]);
            chk("iter_cleared", iteracoes_out, 0);
        end
    endtask

    // Drive handshakes high, drop tem_ativo after stop_after expansions, count pulses until end phase
    task automatic run_job(input int stop_after, input int exp_pulses, input logic exp_err);
        int n = 0;
        int pulses = 0;
        tem_ativo_in  = 1'b1;
        aa_pronto_in  = 1'b1;
        lvv_pronto_in = 1'b1;
        while (n < 60) begin
            nxt();
            n++;
            if (expandir_out) pulses++;
            if (construir_caminho_out || erro_out) break;
            if (atualizar_classificacao_out && !aguardando_out && pulses == stop_after) tem_ativo_in = 1'b0;
        end
        chk("expand_pulses", pulses, exp_pulses);
        chk("erro_end", erro_out, exp_err);
        chk("construir_end", construir_caminho_out, !exp_err);
        tem_ativo_in  = 1'b0;
        aa_pronto_in  = 1'b0;
        lvv_pronto_in = 1'b0;
    endtask

    task automatic finish_ok();
        caminho_pronto_in = 1'b1;
        nxt();
        caminho_pronto_in = 1'b0;
        chk("caminho_pronto", caminho_pronto_out, 1);
        lido_in = 1'b1;
        nxt();
        lido_in = 1'b0;
        chk("back_idle", aguardando_out, 1);
    endtask

    task automatic wait_atu_buf();
        int n = 0;
        while (!atualizar_buffer_out && n < 20) begin
            nxt();
            n++;
        end
        chk("atu_buf_seen", atualizar_buffer_out, 1);
    endtask

    initial begin
        rst = 1'b1;
        req_valid_in = 1'b0; req_origem_in = '0; req_destino_in = '0;
        tem_ativo_in = 1'b0; aa_pronto_in = 1'b0; lvv_pronto_in = 1'b0;
        caminho_pronto_in = 1'b0; lido_in = 1'b0; abortar_in = 1'b0;
        nxt();
        nxt();
        chk("rst_aguardando", aguardando_out, 1);
        chk("rst_ready", req_ready_out, 1);
        chk("rst_fila", fila_nivel_out, 0);
        chk("rst_iter", iteracoes_out, 0);
        chk("rst_origem", origem_out, 0);
        chk("rst_destino", destino_out, 0);
        chk("rst_strobes", {iniciar_out, atualizar_classificacao_out, atualizar_buffer_out, expandir_out,
                            construir_caminho_out, caminho_pronto_out, erro_out}, 0);
        rst = 1'b0;
        nxt();

        // Single job 3 -> 9, two expansions
        push(8'd3, 8'd9, 1'b1);
        chk("pop_classif", atualizar_classificacao_out, 1);
        chk("pop_fila", fila_nivel_out, 1);
        nxt();
        chk("latency_iniciar", iniciar_out, 1);
        expect_start();
        run_job(2, 2, 1'b0);
        chk("job1_iter", iteracoes_out, 2);
        finish_ok();
        chk("job1_iter_hold", iteracoes_out, 2);
        chk("job1_origem_hold", origem_out, 3);
        chk("job1_destino_hold", destino_out, 9);

        // Full queue while the FSM is parked in INICIALIZAR
        push(8'h11, 8'h21, 1'b1);
        nxt();
        push(8'h12, 8'h22, 1'b1);
        push(8'h13, 8'h23, 1'b1);
        push(8'h14, 8'h24, 1'b1);
        push(8'h15, 8'h25, 1'b1);
        chk("full_fila", fila_nivel_out, 4);
        chk("full_ready", req_ready_out, 0);
        push(8'h16, 8'h26, 1'b0);
        chk("full_fila_after_reject", fila_nivel_out, 4);
        for (int j = 0; j < 5; j++) begin
            expect_start();
            run_job(0, 0, 1'b0);
            finish_ok();
        end
        chk("drained_fila", fila_nivel_out, 0);
        chk("sb_drained", sb.size(), 0);

        // Timeout at MAX_ITER, then abort of the next job in EXPANDIR
        push(8'h31, 8'h41, 1'b1);
        push(8'h32, 8'h42, 1'b1);
        push(8'h33, 8'h43, 1'b1);
        expect_start();
        run_job(-1, 3, 1'b1);
        chk("timeout_iter", iteracoes_out, 3);
        lido_in = 1'b1;
        nxt();
        lido_in = 1'b0;
        chk("timeout_idle", aguardando_out, 1);
        chk("timeout_next_pop", atualizar_classificacao_out, 1);
        chk("timeout_iter_hold", iteracoes_out, 3);
        expect_start();
        tem_ativo_in = 1'b1; aa_pronto_in = 1'b1; lvv_pronto_in = 1'b0;
        wait_atu_buf();
        nxt();
        chk("abort_pre_iter", iteracoes_out, 1);
        abortar_in = 1'b1;
        nxt();
        abortar_in = 1'b0;
        tem_ativo_in = 1'b0; aa_pronto_in = 1'b0;
        chk("abort_idle", aguardando_out, 1);
        chk("abort_iter_hold", iteracoes_out, 1);
        chk("abort_expandir_reg", expandir_out, 1);
        chk("abort_pop", atualizar_classificacao_out, 1);
        expect_start();

        // Reset while in EXPANDIR clears the registered strobe and counter
        tem_ativo_in = 1'b1; aa_pronto_in = 1'b1; lvv_pronto_in = 1'b0;
        wait_atu_buf();
        nxt();
        chk("exp_pre_iter", iteracoes_out, 1);
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        tem_ativo_in = 1'b0; aa_pronto_in = 1'b0;
        chk("rstexp_expandir", expandir_out, 0);
        chk("rstexp_iter", iteracoes_out, 0);
        chk("rstexp_origem", origem_out, 0);
        chk("rstexp_idle", aguardando_out, 1);

        // Reset in ATUALIZAR_BUFFER with two queued requests and a request offered
        push(8'h51, 8'h61, 1'b1);
        push(8'h52, 8'h62, 1'b1);
        push(8'h53, 8'h63, 1'b1);
        chk("pre_rst_fila", fila_nivel_out, 2);
        expect_start();
        tem_ativo_in = 1'b1; aa_pronto_in = 1'b1; lvv_pronto_in = 1'b0;
        wait_atu_buf();
        rst = 1'b1;
        req_valid_in = 1'b1; req_origem_in = 8'h77; req_destino_in = 8'h78;
        nxt();
        rst = 1'b0;
        req_valid_in = 1'b0;
        sb.delete();
        chk("rstab_idle", aguardando_out, 1);
        chk("rstab_fila", fila_nivel_out, 0);
        chk("rstab_ready", req_ready_out, 1);
        chk("rstab_iter", iteracoes_out, 0);
        chk("rstab_destino", destino_out, 0);
        chk("rstab_strobes", {iniciar_out, atualizar_classificacao_out, atualizar_buffer_out, expandir_out,
                              construir_caminho_out, caminho_pronto_out, erro_out}, 0);
        tem_ativo_in = 1'b0; aa_pronto_in = 1'b0;
        nxt();
        chk("rstab_next_expandir", expandir_out, 0);
        chk("rstab_next_iniciar", iniciar_out, 0);
        chk("rstab_next_fila", fila_nivel_out, 0);
        chk("rstab_next_classif", atualizar_classificacao_out, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/controlador_busca_parametrizado.md
CONTROLADOR_BUSCA_PARAMETRIZADO -- requirements
Module: controlador_busca_parametrizado

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, width of node-ID fields.
REQ-002 Parameter FIFO_DEPTH, default 4, request-queue entries; SHALL be a power of two, at least 2.
REQ-003 Parameter ITER_WIDTH, default 12, iteration-counter width.
REQ-004 Parameter MAX_ITER, default 4000, expansion limit per job; SHALL be less than 2^ITER_WIDTH.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req_valid_in  in  1  new search request offered.
REQ-008 req_origem_in / req_destino_in  in  ADDR_WIDTH each  source / target node of the request.
REQ-009 req_ready_out  out  1  queue can accept a request (not full).
REQ-010 tem_ativo_in, aa_pronto_in  in  1 each  active-node evaluator: has active node / ready.
REQ-011 lvv_pronto_in, caminho_pronto_in  in  1 each  neighbour expansion done / path build done.
REQ-012 lido_in  in  1  host acknowledges a result (success or error).
REQ-013 abortar_in  in  1  cancel the current job.
REQ-014 aguardando_out, iniciar_out, atualizar_classificacao_out, atualizar_buffer_out, expandir_out, construir_caminho_out, caminho_pronto_out, erro_out  out  1 each  phase strobes and levels.
REQ-015 origem_out / destino_out  out  ADDR_WIDTH each  endpoints of the current job.
REQ-016 iteracoes_out  out  ITER_WIDTH  expansions executed in the current or last job.
REQ-017 fila_nivel_out  out  log2(FIFO_DEPTH)+1  queued-request count.

Function
REQ-018 The request FIFO SHALL accept a write when req_valid_in and req_ready_out are both high, and req_ready_out SHALL be the FIFO not-full flag. A write into a full FIFO is rejected even if a pop occurs in the same cycle.
REQ-019 States: IDLE, INICIALIZAR, TEM_ATIVO, ATUALIZAR_BUFFER, EXPANDIR, CONSTRUIR_CAMINHO, PRONTO, ERRO.
REQ-020 IDLE with FIFO non-empty SHALL pop one entry, load origem_out/destino_out, clear the iteration counter, and go to INICIALIZAR; otherwise it stays in IDLE.
REQ-021 INICIALIZAR goes to TEM_ATIVO when tem_ativo_in and aa_pronto_in are both high.
REQ-022 TEM_ATIVO with aa_pronto_in high:
- tem_ativo_in low goes to CONSTRUIR_CAMINHO.
- tem_ativo_in high with counter equal to MAX_ITER goes to ERRO.
- otherwise goes to ATUALIZAR_BUFFER.
REQ-023 ATUALIZAR_BUFFER goes to EXPANDIR when aa_pronto_in is high; the counter SHALL increment on that transition and never exceed MAX_ITER.
REQ-024 EXPANDIR goes to TEM_ATIVO when lvv_pronto_in is high.
REQ-025 CONSTRUIR_CAMINHO goes to PRONTO when caminho_pronto_in is high.
REQ-026 PRONTO and ERRO go to IDLE when lido_in is high.
REQ-027 abortar_in high in any state other than IDLE SHALL force IDLE at the next edge, with priority over all other transitions. The FIFO is untouched and iteracoes_out holds its value.
REQ-028 Output decodes:
- aguardando_out = IDLE.
- iniciar_out = INICIALIZAR.
- construir_caminho_out = CONSTRUIR_CAMINHO.
- caminho_pronto_out = PRONTO.
- erro_out = ERRO.
REQ-029 atualizar_classificacao_out = TEM_ATIVO, or IDLE in a pop cycle.
REQ-030 atualizar_buffer_out = ATUALIZAR_BUFFER and aa_pronto_in.
REQ-031 expandir_out SHALL be registered: high in the cycle after each cycle the state is EXPANDIR.
REQ-032 iteracoes_out, origem_out and destino_out SHALL hold after PRONTO, ERRO or abort until the next pop.
REQ-033 Latency: a request accepted in cycle N into an empty FIFO with the FSM in IDLE SHALL pop in cycle N+1, with iniciar_out high in cycle N+2.

Reset
REQ-034 rst high at a clock edge SHALL set the following regardless of state:
- state to IDLE and FIFO empty.
- fila_nivel_out to 0 and req_ready_out to 1.
- counter, origem_out and destino_out to 0.
- all 1-bit outputs except aguardando_out and req_ready_out to 0, including registered expandir_out.
REQ-035 rst asserted mid-job or together with req_valid_in SHALL discard the job and the incoming request.

Verification
REQ-036 Single job: push (origem 3, destino 9); 2 expansions; tem_ativo_in low; caminho_pronto_in; lido_in.
- Required: iniciar_out at N+2; 2 expandir_out pulses; caminho_pronto_out; iteracoes_out=2; origem_out=3; destino_out=9.
REQ-037 Full queue: push 5 requests back-to-back with FSM held busy.
- Required: 4 accepted; req_ready_out low after the 4th; 5th rejected; jobs executed in FIFO order.
REQ-038 Timeout: MAX_ITER=3, tem_ativo_in always high.
- Required: 3 expansions, then ERRO; erro_out=1; iteracoes_out=3; lido_in returns to IDLE; next queued job starts.
REQ-039 Abort in EXPANDIR after 1 expansion.
- Required: IDLE next cycle; iteracoes_out=1; queued job pops the following cycle.
REQ-040 rst pulsed in ATUALIZAR_BUFFER with 2 queued requests.
- Required: IDLE; fila_nivel_out=0; all strobes 0; expandir_out 0 in the next cycle.
